// File: rtl/ex_mem_stage_reg_if.sv
// EX/MEM boundary bus: per-lane valids and payload toward MEM, plus the
// stall/flush controls and the multi-cycle context loop back to EX.
interface ex_mem_stage_reg_if #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 160,
    parameter int CTX_W   = 66,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic [LANES-1:0]        in_valid;
    logic [LANES-1:0]        kill_i;
    logic [LANES*DATA_W-1:0] in_data;
    logic [CTX_W-1:0]        ctx_i;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;
    logic [CTX_W-1:0]        ctx_o;

    modport master (
        output stall, flush, in_valid, kill_i, in_data, ctx_i,
        input  out_valid, out_data, ctx_o
    );

    modport slave (
        input  stall, flush, in_valid, kill_i, in_data, ctx_i,
        output out_valid, out_data, ctx_o
    );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// Multi-lane EX/MEM pipeline register with flush/bubble/hold handling,
// in-order lane squash, multi-cycle context retention and perf counters.
module ex_mem_stage_reg #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 160,
    parameter int CTX_W   = 66,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ex_mem_stage_reg_if.slave     bus,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      bubble_cycles_o
);
    logic                    s_w;
    logic                    d_w;
    logic                    bubble_w;
    logic [LANES-1:0]        kill_eff;
    logic [LANES-1:0]        valid_next;
    logic [LANES*DATA_W-1:0] data_next;

    logic [LANES-1:0]        valid_reg;
    logic [LANES*DATA_W-1:0] data_reg;
    logic [CTX_W-1:0]        ctx_reg;
    logic [CNT_W-1:0]        stall_cnt_reg;
    logic [CNT_W-1:0]        bubble_cnt_reg;

    assign s_w      = bus.stall[STAGE];
    assign d_w      = bus.stall[STAGE+1];
    assign bubble_w = s_w & ~d_w;

    // A kill on an older lane squashes every younger lane as well.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign kill_eff[gi]   = |bus.kill_i[gi:0];
        assign valid_next[gi] = bus.in_valid[gi] & ~kill_eff[gi];
        assign data_next[gi*DATA_W +: DATA_W] =
            valid_next[gi] ? bus.in_data[gi*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            data_reg  <= '0;
            ctx_reg   <= '0;
        end else if (bus.flush) begin
            valid_reg <= '0;
            data_reg  <= '0;
            ctx_reg   <= '0;
        end else if (bubble_w) begin
            valid_reg <= '0;
            data_reg  <= '0;
            ctx_reg   <= bus.ctx_i;
        end else if (!s_w) begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
            ctx_reg   <= '0;
        end else begin
            // Held: payload frozen, EX keeps its partial multi-cycle result.
            ctx_reg   <= bus.ctx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (s_w && !bus.flush && stall_cnt_reg != {CNT_W{1'b1}})
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (bubble_w && !bus.flush && bubble_cnt_reg != {CNT_W{1'b1}})
                bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.out_valid    = valid_reg;
    assign bus.out_data     = data_reg;
    assign bus.ctx_o        = ctx_reg;
    assign stall_cycles_o   = stall_cnt_reg;
    assign bubble_cycles_o  = bubble_cnt_reg;
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg (2 lanes, CNT_W=4 so saturation is reachable).
module tb_ex_mem_stage_reg;
    localparam int LANES   = 2;
    localparam int DATA_W  = 160;
    localparam int CTX_W   = 66;
    localparam int STALL_W = 6;
    localparam int STAGE   = 3;
    localparam int CNT_W   = 4;
    localparam int W       = LANES * DATA_W;

    localparam logic [DATA_W-1:0] LANE_A = {40{4'hA}};
    localparam logic [DATA_W-1:0] LANE_B = {40{4'hB}};
    localparam logic [DATA_W-1:0] LANE_C = {40{4'hC}};
    localparam logic [CTX_W-1:0]  CTX1   = 66'h2_1234_5678_9ABC_DEF0;
    localparam logic [CTX_W-1:0]  CTX2   = 66'h1_0F0F_0F0F_AAAA_5555;

    logic clk = 1'b0;
    logic rst;
    logic perf_clr;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] bubble_cycles_o;

    int vectors = 0;
    int miscompares = 0;

    ex_mem_stage_reg_if #(.LANES(LANES), .DATA_W(DATA_W), .CTX_W(CTX_W), .STALL_W(STALL_W)) bus ();

    ex_mem_stage_reg #(
        .LANES(LANES), .DATA_W(DATA_W), .CTX_W(CTX_W),
        .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .perf_clr        (perf_clr),
        .stall_cycles_o  (stall_cycles_o),
        .bubble_cycles_o (bubble_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [LANES-1:0] v, input logic [W-1:0] d,
                           input logic [CTX_W-1:0] c, input logic [CNT_W-1:0] sc,
                           input logic [CNT_W-1:0] bc);
        chk({tag, ".valid"}, W'(bus.out_valid), W'(v));
        chk({tag, ".data"},  bus.out_data, d);
        chk({tag, ".ctx"},   W'(bus.ctx_o), W'(c));
        chk({tag, ".stall_cnt"},  W'(stall_cycles_o),  W'(sc));
        chk({tag, ".bubble_cnt"}, W'(bubble_cycles_o), W'(bc));
        $display("step %-10s valid=%b ctx=%0h stall_cnt=%0d bubble_cnt=%0d",
                 tag, bus.out_valid, bus.ctx_o, stall_cycles_o, bubble_cycles_o);
    endtask

    initial begin
        // Reset while inputs carry junk and a stall is active.
        rst = 1'b1; perf_clr = 1'b0;
        bus.stall = 6'b001111; bus.flush = 1'b0;
        bus.in_valid = 2'b11; bus.kill_i = 2'b00;
        bus.in_data = {LANE_B, LANE_A}; bus.ctx_i = CTX1;
        tick();
        chk_all("reset", 2'b00, '0, '0, 4'd0, 4'd0);

        // Plain advance of two valid lanes.
        rst = 1'b0; bus.stall = 6'b000000;
        tick();
        chk_all("advance", 2'b11, {LANE_B, LANE_A}, '0, 4'd0, 4'd0);

        // Three bubble cycles: ctx_o follows ctx_i each cycle.
        bus.stall = 6'b001111;
        for (int i = 0; i < 3; i++) begin
            bus.ctx_i = CTX1 + CTX_W'(i);
            tick();
            chk_all("bubble", 2'b00, '0, CTX1 + CTX_W'(i), CNT_W'(i + 1), CNT_W'(i + 1));
        end

        // Refill, then hold with changing inputs: payload must stay frozen.
        bus.stall = 6'b000000; bus.in_valid = 2'b11; bus.in_data = {LANE_B, LANE_A};
        tick();
        chk_all("refill", 2'b11, {LANE_B, LANE_A}, '0, 4'd3, 4'd3);

        bus.stall = 6'b011111; bus.ctx_i = CTX2;
        bus.in_valid = 2'b00; bus.in_data = {LANE_C, LANE_C}; bus.kill_i = 2'b01;
        tick();
        chk_all("hold", 2'b11, {LANE_B, LANE_A}, CTX2, 4'd4, 4'd3);

        // Kill on lane 0 squashes both lanes.
        bus.stall = 6'b000000; bus.in_valid = 2'b11; bus.in_data = {LANE_B, LANE_A};
        bus.kill_i = 2'b01;
        tick();
        chk_all("kill01", 2'b00, '0, '0, 4'd4, 4'd3);

        // Kill on lane 1 squashes only lane 1.
        bus.kill_i = 2'b10;
        tick();
        chk_all("kill10", 2'b01, {{DATA_W{1'b0}}, LANE_A}, '0, 4'd4, 4'd3);

        // Flush during a bubble: everything clears, counters frozen.
        bus.kill_i = 2'b00; bus.stall = 6'b001111; bus.flush = 1'b1; bus.ctx_i = CTX1;
        tick();
        chk_all("flush", 2'b00, '0, '0, 4'd4, 4'd3);

        // Only the older lane invalid: younger lane still passes.
        bus.flush = 1'b0; bus.stall = 6'b000000; bus.in_valid = 2'b10;
        tick();
        chk_all("lane1only", 2'b10, {LANE_B, {DATA_W{1'b0}}}, '0, 4'd4, 4'd3);

        // 2^CNT_W+5 stalled cycles: both counters saturate at 15.
        bus.stall = 6'b001111; bus.ctx_i = CTX2;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
        chk_all("saturate", 2'b00, '0, CTX2, 4'd15, 4'd15);

        // perf_clr beats an increment in the same cycle.
        perf_clr = 1'b1;
        tick();
        chk_all("perf_clr", 2'b00, '0, CTX2, 4'd0, 4'd0);

        perf_clr = 1'b0; bus.stall = 6'b011111; bus.ctx_i = CTX1;
        tick();
        chk_all("hold2", 2'b00, '0, CTX1, 4'd1, 4'd0);

        // Refill, then reset in the middle of a hold.
        bus.stall = 6'b000000; bus.in_valid = 2'b11;
        tick();
        chk_all("refill2", 2'b11, {LANE_B, LANE_A}, '0, 4'd1, 4'd0);

        rst = 1'b1; bus.stall = 6'b011111; bus.flush = 1'b1; bus.ctx_i = CTX2;
        tick();
        chk_all("rst_mid", 2'b00, '0, '0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
